ac_exec_unit: RTL and testbench
===============================

# ac_exec_unit

Sequential execution controller that drives the accumulator datapath of the Basic Computer through the shared combinational ALU. It accepts one accumulator-class command at a time over a valid/ready handshake and fetches the memory operand when one is needed. It sequences the ALU opcode and operands, latches the ALU result into AC/E, and reports completion with a skip indication. It sits between the instruction decoder (upstream) and the ALU and memory read port (downstream).

## Interface
- W, 16, datapath width (AC, DR, memory word)
- AW, 12, memory address width
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  reset, synchronous, active-low
- req_valid  in  1  command present
- req_ready  out  1  unit can accept; high only in IDLE
- req_cmd  in  4  command code (see Operation)
- req_addr  in  AW  operand address for memory commands
- mem_rd_en  out  1  memory read request; held until mem_rd_valid
- mem_addr  out  AW  read address; stable while mem_rd_en high
- mem_rd_valid  in  1  read data valid; ignored unless in MEM state
- mem_rd_data  in  W  read data
- alu_op  out  3  ALU opcode (000 ADD, 001 AND, 010 DR, 011 ~AC, 100 SHR, 101 SHL, 110 AC)
- alu_ac, alu_dr  out  W each  driven from AC and DR registers
- alu_e_in  out  1  driven from E register
- alu_out  in  W; alu_e_out, alu_z, alu_n, alu_ovf  in  1 each  ALU results
- ac  out  W  accumulator register
- e  out  1  E (carry/link) register
- ovf  out  1  overflow flag, updated on ADD only
- done  out  1  one-cycle completion pulse
- skip  out  1  valid with done; 1 = skip condition true
- err  out  1  valid with done; 1 = illegal command

## Operation
- Commands: 0 AND, 1 ADD, 2 LDA (memory); 3 CLA, 4 CLE, 5 CMA, 6 CME, 7 CIR, 8 CIL, 9 INC (register); A SPA, B SNA, C SZA, D SZE (skip); E, F illegal.
- States: IDLE, MEM, EXEC, DONE.
- IDLE: req_ready=1. On req_valid: latch cmd/addr. Memory command -> MEM. CLA: DR<=0, INC: DR<=1. All other legal commands -> EXEC. Illegal -> DONE with err=1, no register change.
- MEM: mem_rd_en=1, mem_addr=latched addr. On mem_rd_valid: DR<=mem_rd_data, -> EXEC. Waits indefinitely.
- EXEC: alu_op per command, results latched at end of cycle, -> DONE.
  - AND (001): AC<=alu_out; E unchanged.
  - ADD (000): AC<=alu_out, E<=alu_e_out, ovf<=alu_ovf.
  - LDA (010): AC<=alu_out.
  - CLA (001 with DR=0): AC<=0.
  - INC (000 with DR=1): AC<=alu_out, E<=alu_e_out, ovf<=alu_ovf.
  - CMA (011): AC<=alu_out.
  - CIR (100), CIL (101): AC<=alu_out, E<=alu_e_out.
  - CLE: E<=0. CME: E<=~E. alu_op=110, AC unchanged.
  - SPA: skip<=~alu_n & ~alu_z. SNA: skip<=alu_n. SZA: skip<=alu_z. SZE: skip<=~E. All use alu_op=110; AC and E unchanged.
- DONE: done=1 for exactly one cycle, skip/err valid, -> IDLE. skip and err are 0 for commands outside their class.
- Outside EXEC, alu_op=110.
- Arithmetic is modulo 2^W. The carry goes to E only, never to AC.

## Timing
- Reset (rst_n=0 at a clock edge): state=IDLE, ac=0, DR=0, e=0, ovf=0, done=0, skip=0, err=0, mem_rd_en=0. This applies from any state. An outstanding read is abandoned and its late mem_rd_valid is ignored.
- Register and skip commands: accepted at edge T, EXEC during cycle T+1, done high during cycle T+2, req_ready high again in cycle T+3.
- Memory commands: mem_rd_en rises in cycle T+1. If mem_rd_valid arrives in cycle T+1+k, EXEC runs in T+2+k and done is high in T+3+k. The minimum is done in T+3.
- Illegal command: done with err=1 in cycle T+1.
- Updated ac/e become visible in the same cycle done is high.
- req_valid while req_ready=0 is ignored; the command is not queued.
- mem_rd_valid and reset in the same cycle: reset wins and DR is not written.

## Test plan
- Reset values: assert rst_n=0 mid-MEM with mem_rd_en high -> next cycle all outputs 0, state IDLE; a later mem_rd_valid leaves ac=0.
- Memory ADD with carry: LDA with mem=0xFFFF, then ADD with mem=0x0001 -> ac=0x0000, e=1, ovf=0. Then SZA -> done with skip=1.
- Signed overflow: LDA 0x7FFF, INC -> ac=0x8000, e=0, ovf=1. Then SNA -> skip=1; SPA -> skip=0.
- Rotates: ac=0x8001, e=0. CIR -> ac=0x4000, e=1. CIL -> ac=0x8001, e=0. CME -> e=1; CLE -> e=0; SZE -> skip=1.
- Handshake latency: CMA on ac=0x00FF -> done exactly 2 cycles after accept, ac=0xFF00. Memory AND with 3-cycle read stall -> done 5 cycles after accept, mem_addr stable throughout. req_valid held during busy -> only one command executed.
- Illegal command 0xE -> done and err=1 one cycle after accept; ac, e, ovf unchanged.

Source files
------------

// File: rtl/ac_exec_unit.sv
// Accumulator execution controller for the Basic Computer.
// Sequences ALU ops, fetches memory operands, latches AC/E/ovf.
module ac_exec_unit #(
  parameter int W  = 16,
  parameter int AW = 12
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [3:0]    req_cmd,
  input  logic [AW-1:0] req_addr,
  output logic          mem_rd_en,
  output logic [AW-1:0] mem_addr,
  input  logic          mem_rd_valid,
  input  logic [W-1:0]  mem_rd_data,
  output logic [2:0]    alu_op,
  output logic [W-1:0]  alu_ac,
  output logic [W-1:0]  alu_dr,
  output logic          alu_e_in,
  input  logic [W-1:0]  alu_out,
  input  logic          alu_e_out,
  input  logic          alu_z,
  input  logic          alu_n,
  input  logic          alu_ovf,
  output logic [W-1:0]  ac,
  output logic          e,
  output logic          ovf,
  output logic          done,
  output logic          skip,
  output logic          err
);

  localparam logic [3:0] C_AND = 4'h0;
  localparam logic [3:0] C_ADD = 4'h1;
  localparam logic [3:0] C_LDA = 4'h2;
  localparam logic [3:0] C_CLA = 4'h3;
  localparam logic [3:0] C_CLE = 4'h4;
  localparam logic [3:0] C_CMA = 4'h5;
  localparam logic [3:0] C_CME = 4'h6;
  localparam logic [3:0] C_CIR = 4'h7;
  localparam logic [3:0] C_CIL = 4'h8;
  localparam logic [3:0] C_INC = 4'h9;
  localparam logic [3:0] C_SPA = 4'hA;
  localparam logic [3:0] C_SNA = 4'hB;
  localparam logic [3:0] C_SZA = 4'hC;
  localparam logic [3:0] C_SZE = 4'hD;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_AND = 3'b001;
  localparam logic [2:0] OP_DR  = 3'b010;
  localparam logic [2:0] OP_CMA = 3'b011;
  localparam logic [2:0] OP_SHR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_AC  = 3'b110;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MEM,
    S_EXEC,
    S_DONE
  } state_t;

  state_t        state;
  logic [3:0]    cmd;
  logic [AW-1:0] addr;
  logic [W-1:0]  dr;

  assign req_ready = (state == S_IDLE);
  assign mem_addr  = addr;
  assign alu_ac    = ac;
  assign alu_dr    = dr;
  assign alu_e_in  = e;

  // ALU opcode: command-specific in EXEC, pass-through AC otherwise
  always_comb begin
    alu_op = OP_AC;
    if (state == S_EXEC) begin
      unique case (cmd)
        C_AND, C_CLA: alu_op = OP_AND;
        C_ADD, C_INC: alu_op = OP_ADD;
        C_LDA:        alu_op = OP_DR;
        C_CMA:        alu_op = OP_CMA;
        C_CIR:        alu_op = OP_SHR;
        C_CIL:        alu_op = OP_SHL;
        default:      alu_op = OP_AC;
      endcase
    end
  end

  // Control FSM with registered datapath state and status outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cmd       <= '0;
      addr      <= '0;
      dr        <= '0;
      ac        <= '0;
      e         <= 1'b0;
      ovf       <= 1'b0;
      done      <= 1'b0;
      skip      <= 1'b0;
      err       <= 1'b0;
      mem_rd_en <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (req_valid) begin
            cmd  <= req_cmd;
            addr <= req_addr;
            if (req_cmd <= C_LDA) begin
              state     <= S_MEM;
              mem_rd_en <= 1'b1;
            end else if (req_cmd >= 4'hE) begin
              state <= S_DONE;
              done  <= 1'b1;
              err   <= 1'b1;
              skip  <= 1'b0;
            end else begin
              state <= S_EXEC;
              if (req_cmd == C_CLA) dr <= '0;
              if (req_cmd == C_INC) dr <= W'(1);
            end
          end
        end
        S_MEM: begin
          if (mem_rd_valid) begin
            dr        <= mem_rd_data;
            mem_rd_en <= 1'b0;
            state     <= S_EXEC;
          end
        end
        S_EXEC: begin
          state <= S_DONE;
          done  <= 1'b1;
          err   <= 1'b0;
          skip  <= 1'b0;
          unique case (cmd)
            C_AND, C_LDA, C_CLA, C_CMA: ac <= alu_out;
            C_ADD, C_INC: begin
              ac  <= alu_out;
              e   <= alu_e_out;
              ovf <= alu_ovf;
            end
            C_CIR, C_CIL: begin
              ac <= alu_out;
              e  <= alu_e_out;
            end
            C_CLE: e <= 1'b0;
            C_CME: e <= ~e;
            C_SPA: skip <= ~alu_n & ~alu_z;
            C_SNA: skip <= alu_n;
            C_SZA: skip <= alu_z;
            C_SZE: skip <= ~e;
            default: ;
          endcase
        end
        S_DONE: begin
          state <= S_IDLE;
          done  <= 1'b0;
          skip  <= 1'b0;
          err   <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ac_exec_unit.sv
// Directed bench for ac_exec_unit with a behavioural ALU and memory.
// Each scenario task drives commands and checks results inline.
module tb_ac_exec_unit;

  logic        clk = 0;
  logic        rst_n = 0;
  logic        req_valid = 0;
  logic        req_ready;
  logic [3:0]  req_cmd = 0;
  logic [11:0] req_addr = 0;
  logic        mem_rd_en;
  logic [11:0] mem_addr;
  logic        mem_rd_valid = 0;
  logic [15:0] mem_rd_data = 0;
  logic [2:0]  alu_op;
  logic [15:0] alu_ac, alu_dr;
  logic        alu_e_in;
  logic [15:0] alu_out;
  logic        alu_e_out, alu_z, alu_n, alu_ovf;
  logic [15:0] ac;
  logic        e, ovf, done, skip, err;

  int total = 0;
  int bad = 0;

  ac_exec_unit dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_cmd(req_cmd), .req_addr(req_addr),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
    .mem_rd_valid(mem_rd_valid), .mem_rd_data(mem_rd_data),
    .alu_op(alu_op), .alu_ac(alu_ac), .alu_dr(alu_dr),
    .alu_e_in(alu_e_in), .alu_out(alu_out),
    .alu_e_out(alu_e_out), .alu_z(alu_z), .alu_n(alu_n),
    .alu_ovf(alu_ovf),
    .ac(ac), .e(e), .ovf(ovf),
    .done(done), .skip(skip), .err(err)
  );

  always #5 clk = ~clk;

  // Reference combinational ALU
  always_comb begin
    logic [16:0] s;
    s = {1'b0, alu_ac} + {1'b0, alu_dr};
    alu_out   = alu_ac;
    alu_e_out = alu_e_in;
    alu_ovf   = 1'b0;
    case (alu_op)
      3'b000: begin
        alu_out   = s[15:0];
        alu_e_out = s[16];
        alu_ovf   = (alu_ac[15] == alu_dr[15]) && (s[15] != alu_ac[15]);
      end
      3'b001: alu_out = alu_ac & alu_dr;
      3'b010: alu_out = alu_dr;
      3'b011: alu_out = ~alu_ac;
      3'b100: begin
        alu_out   = {alu_e_in, alu_ac[15:1]};
        alu_e_out = alu_ac[0];
      end
      3'b101: begin
        alu_out   = {alu_ac[14:0], alu_e_in};
        alu_e_out = alu_ac[15];
      end
      default: alu_out = alu_ac;
    endcase
    alu_z = (alu_out == 16'h0);
    alu_n = alu_out[15];
  end

  // Issue one command; serve memory with k wait cycles; return at done
  task automatic issue(input logic [3:0] c, input logic [11:0] a,
                       input logic [15:0] d, input int k, input bit hold,
                       output int lat, output logic sk, output logic er,
                       output bit addr_ok);
    int n, s;
    lat = -1; sk = 0; er = 0; addr_ok = 1; n = 0; s = 0;
    @(negedge clk);
    req_valid = 1; req_cmd = c; req_addr = a;
    @(posedge clk);
    @(negedge clk);
    if (!hold) req_valid = 0;
    while (n < 60) begin
      n++;
      mem_rd_valid = 0;
      if (done) begin
        lat = n; sk = skip; er = err;
        break;
      end
      if (mem_rd_en) begin
        if (mem_addr !== a) addr_ok = 0;
        if (s == k) begin
          mem_rd_valid = 1; mem_rd_data = d;
        end
        s++;
      end
      @(negedge clk);
    end
    mem_rd_valid = 0;
    req_valid = 0;
    total++;
    if (lat < 0) begin
      bad++;
      $display("FAIL timeout cmd=%h: no done within 60 cycles", c);
    end
  endtask

  task automatic test_reset();
    int lat; logic sk, er; bit ok;
    rst_n = 0;
    repeat (2) @(negedge clk);
    total++;
    if ({ac, e, ovf, done, skip, err, mem_rd_en, req_ready} !== {16'h0, 7'b0, 1'b1}) begin
      bad++;
      $display("FAIL por_state: ac=%h e=%b ovf=%b done=%b rdy=%b need zeros rdy=1",
               ac, e, ovf, done, req_ready);
    end
    rst_n = 1;
    issue(4'h2, 12'h010, 16'h5A5A, 0, 0, lat, sk, er, ok);
    issue(4'h6, 12'h000, 16'h0, 0, 0, lat, sk, er, ok);
    total++;
    if (ac !== 16'h5A5A || e !== 1'b1) begin
      bad++;
      $display("FAIL pre_reset_load: ac=%h e=%b need 5a5a 1", ac, e);
    end
    @(negedge clk);
    req_valid = 1; req_cmd = 4'h2; req_addr = 12'h123;
    @(negedge clk);
    req_valid = 0;
    total++;
    if (mem_rd_en !== 1'b1) begin
      bad++;
      $display("FAIL mem_rd_en_up: got %b need 1", mem_rd_en);
    end
    rst_n = 0; mem_rd_valid = 1; mem_rd_data = 16'h1234;
    @(negedge clk);
    mem_rd_valid = 0; rst_n = 1;
    total++;
    if ({ac, e, ovf, done, skip, err, mem_rd_en} !== 23'h0 ||
        req_ready !== 1'b1 || alu_dr !== 16'h0 || alu_op !== 3'b110) begin
      bad++;
      $display("FAIL mid_mem_reset: ac=%h e=%b en=%b rdy=%b dr=%h op=%b",
               ac, e, mem_rd_en, req_ready, alu_dr, alu_op);
    end
    mem_rd_valid = 1; mem_rd_data = 16'hBEEF;
    @(negedge clk);
    mem_rd_valid = 0;
    repeat (3) @(negedge clk);
    total++;
    if (ac !== 16'h0 || done !== 1'b0 || alu_dr !== 16'h0 || mem_rd_en !== 1'b0) begin
      bad++;
      $display("FAIL late_valid: ac=%h done=%b dr=%h need 0", ac, done, alu_dr);
    end
  endtask

  task automatic test_add_carry();
    int lat; logic sk, er; bit ok;
    issue(4'h2, 12'h001, 16'hFFFF, 0, 0, lat, sk, er, ok);
    total++;
    if (lat !== 3 || ac !== 16'hFFFF) begin
      bad++;
      $display("FAIL lda_ffff: lat=%0d ac=%h need 3 ffff", lat, ac);
    end
    issue(4'h1, 12'h002, 16'h0001, 0, 0, lat, sk, er, ok);
    total++;
    if (ac !== 16'h0000 || e !== 1'b1 || ovf !== 1'b0) begin
      bad++;
      $display("FAIL add_carry: ac=%h e=%b ovf=%b need 0000 1 0", ac, e, ovf);
    end
    issue(4'hC, 12'h0, 16'h0, 0, 0, lat, sk, er, ok);
    total++;
    if (sk !== 1'b1 || er !== 1'b0 || lat !== 2) begin
      bad++;
      $display("FAIL sza: skip=%b err=%b lat=%0d need 1 0 2", sk, er, lat);
    end
  endtask

  task automatic test_overflow();
    int lat; logic sk, er; bit ok;
    issue(4'h2, 12'h003, 16'h7FFF, 0, 0, lat, sk, er, ok);
    issue(4'h9, 12'h0, 16'h0, 0, 0, lat, sk, er, ok);
    total++;
    if (ac !== 16'h8000 || e !== 1'b0 || ovf !== 1'b1 || lat !== 2) begin
      bad++;
      $display("FAIL inc_ovf: ac=%h e=%b ovf=%b lat=%0d need 8000 0 1 2",
               ac, e, ovf, lat);
    end
    issue(4'hB, 12'h0, 16'h0, 0, 0, lat, sk, er, ok);
    total++;
    if (sk !== 1'b1) begin
      bad++;
      $display("FAIL sna: skip=%b need 1", sk);
    end
    issue(4'hA, 12'h0, 16'h0, 0, 0, lat, sk, er, ok);
    total++;
    if (sk !== 1'b0 || ac !== 16'h8000) begin
      bad++;
      $display("FAIL spa: skip=%b ac=%h need 0 8000", sk, ac);
    end
  endtask

  task automatic test_rotates();
    int lat; logic sk, er; bit ok;
    issue(4'h2, 12'h004, 16'h8001, 0, 0, lat, sk, er, ok);
    issue(4'h4, 12'h0, 16'h0, 0, 0, lat, sk, er, ok);
    issue(4'h7, 12'h0, 16'h0, 0, 0, lat, sk, er, ok);
    total++;
    if (ac !== 16'h4000 || e !== 1'b1 || ovf !== 1'b1) begin
      bad++;
      $display("FAIL cir: ac=%h e=%b ovf=%b need 4000 1 1", ac, e, ovf);
    end
    issue(4'h8, 12'h0, 16'h0, 0, 0, lat, sk, er, ok);
    total++;
    if (ac !== 16'h8001 || e !== 1'b0) begin
      bad++;
      $display("FAIL cil: ac=%h e=%b need 8001 0", ac, e);
    end
    issue(4'h6, 12'h0, 16'h0, 0, 0, lat, sk, er, ok);
    total++;
    if (e !== 1'b1 || ac !== 16'h8001) begin
      bad++;
      $display("FAIL cme: e=%b ac=%h need 1 8001", e, ac);
    end
    issue(4'hD, 12'h0, 16'h0, 0, 0, lat, sk, er, ok);
    total++;
    if (sk !== 1'b0) begin
      bad++;
      $display("FAIL sze_e1: skip=%b need 0", sk);
    end
    issue(4'h4, 12'h0, 16'h0, 0, 0, lat, sk, er, ok);
    issue(4'hD, 12'h0, 16'h0, 0, 0, lat, sk, er, ok);
    total++;
    if (e !== 1'b0 || sk !== 1'b1) begin
      bad++;
      $display("FAIL cle_sze: e=%b skip=%b need 0 1", e, sk);
    end
  endtask

  task automatic test_latency();
    int lat, nd; logic sk, er; bit ok;
    issue(4'h2, 12'h005, 16'h00FF, 0, 0, lat, sk, er, ok);
    issue(4'h5, 12'h0, 16'h0, 0, 0, lat, sk, er, ok);
    total++;
    if (lat !== 2 || ac !== 16'hFF00) begin
      bad++;
      $display("FAIL cma_lat: lat=%0d ac=%h need 2 ff00", lat, ac);
    end
    issue(4'h0, 12'hABC, 16'h0F0F, 2, 0, lat, sk, er, ok);
    total++;
    if (lat !== 5 || ac !== 16'h0F00 || ok !== 1'b1) begin
      bad++;
      $display("FAIL and_stall: lat=%0d ac=%h addr_ok=%b need 5 0f00 1",
               lat, ac, ok);
    end
    issue(4'h5, 12'h0, 16'h0, 0, 1, lat, sk, er, ok);
    nd = 0;
    repeat (5) begin
      @(negedge clk);
      if (done) nd++;
    end
    total++;
    if (lat !== 2 || ac !== 16'hF0FF || nd !== 0) begin
      bad++;
      $display("FAIL busy_hold: lat=%0d ac=%h extra_done=%0d need 2 f0ff 0",
               lat, ac, nd);
    end
    issue(4'h3, 12'h0, 16'h0, 0, 0, lat, sk, er, ok);
    total++;
    if (lat !== 2 || ac !== 16'h0000) begin
      bad++;
      $display("FAIL cla: lat=%0d ac=%h need 2 0000", lat, ac);
    end
  endtask

  task automatic test_illegal();
    int lat; logic sk, er; bit ok;
    issue(4'h2, 12'h006, 16'h1357, 0, 0, lat, sk, er, ok);
    issue(4'h6, 12'h0, 16'h0, 0, 0, lat, sk, er, ok);
    issue(4'hE, 12'h0, 16'h0, 0, 0, lat, sk, er, ok);
    total++;
    if (lat !== 1 || er !== 1'b1 || sk !== 1'b0) begin
      bad++;
      $display("FAIL illegal_e: lat=%0d err=%b skip=%b need 1 1 0", lat, er, sk);
    end
    total++;
    if (ac !== 16'h1357 || e !== 1'b1 || ovf !== 1'b1) begin
      bad++;
      $display("FAIL illegal_regs: ac=%h e=%b ovf=%b need 1357 1 1", ac, e, ovf);
    end
    issue(4'hF, 12'h0, 16'h0, 0, 0, lat, sk, er, ok);
    total++;
    if (lat !== 1 || er !== 1'b1 || ac !== 16'h1357) begin
      bad++;
      $display("FAIL illegal_f: lat=%0d err=%b ac=%h need 1 1 1357", lat, er, ac);
    end
    issue(4'hC, 12'h0, 16'h0, 0, 0, lat, sk, er, ok);
    total++;
    if (er !== 1'b0 || sk !== 1'b0) begin
      bad++;
      $display("FAIL err_clear: err=%b skip=%b need 0 0", er, sk);
    end
  endtask

  initial begin
    test_reset();
    test_add_carry();
    test_overflow();
    test_rotates();
    test_latency();
    test_illegal();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
